rc5_decrypt_pipe: RTL and testbench
===================================

// Module: rc5_decrypt_pipe
// PURPOSE
//  Fully pipelined RC5-32/12/16 decryptor; inverse of the 12-stage pipelined encryptor.
//  Accepts one 64-bit ciphertext per cycle from the encrypt output/channel side.
//  Returns plaintext after ROUNDS+1 cycles.
//  Valid/ready handshake on both ends; one global stall with no bubble collapse.
//  Takes the 26-word expanded key from keyGen.
// PARAMETERS
//  ROUNDS   12   number of RC5 rounds; pipeline depth is ROUNDS+1 stages
//  W        32   word width (fixed at 32; rotation amount uses bits [4:0])
// PORTS
//  clk      in   1    single clock, rising edge
//  clr      in   1    asynchronous, active-low reset
//  skey_in  in   832  expanded key; S[k] = skey_in[32*k+31 -: 32], k=0..25
//  din      in   64   ciphertext {A[63:32], B[31:0]}
//  di_vld   in   1    din valid
//  di_rdy   out  1    block can accept din this cycle
//  dout     out  64   plaintext {A[63:32], B[31:0]}
//  do_vld   out  1    dout valid
//  do_rdy   in   1    sink accepts dout this cycle
//  occ      out  4    number of blocks in flight (0..ROUNDS+1)
//  busy     out  1    occ != 0
// BEHAVIOUR
//  Reset (clr=0, async): all stage valid bits 0, all stage data 0, dout=0, do_vld=0, occ=0, busy=0.
//  Reset mid-operation discards all in-flight blocks with no output.
//  Advance enable: en = do_rdy | ~do_vld. di_rdy = en (combinational).
//   - en=1: every stage shifts.
//   - en=0: every stage holds data and valid.
//  Input transfer when di_vld & di_rdy. Stage 1 valid <= di_vld & en.
//  Output transfer when do_vld & do_rdy.
//  Stage k (k=1..ROUNDS), with i = ROUNDS+1-k (i = 12 down to 1), in this order:
//   B' = ROTR(B - S[2i+1], A[4:0]) ^ A
//   A' = ROTR(A - S[2i],   B'[4:0]) ^ B'   (uses the NEW B')
//  Final stage (ROUNDS+1): B = B - S[1]; A = A - S[0]; result registered to dout/do_vld.
//  Arithmetic: all add/sub mod 2^32; ROTR by 0 is the identity (no shift-by-32 artefacts).
//  Each stage is purely registered; no combinational path from din to dout.
//  Latency: ROUNDS+1 = 13 enabled cycles from input transfer to do_vld=1.
//  Throughput: 1 block/cycle while do_rdy=1.
//  occ:
//   - +1 on input transfer only; -1 on output transfer only.
//   - Unchanged when both occur in the same cycle, or when neither occurs.
//   - Never exceeds ROUNDS+1; with do_rdy=0 and a full pipe, di_rdy=0.
//  Bubbles (di_vld=0 while en=1) propagate as invalid stages; dout holds its last value while do_vld=0.
//  skey_in must be stable while busy=1; it is not latched. Changing it mid-flight corrupts in-flight results (not checked).
//  X on din while di_vld=0 must not propagate into valid outputs.
// TESTING
//  T1 zero: skey_in=0, din=64'h0, di_vld=1 one cycle, do_rdy=1
//     -> do_vld=1 exactly 13 cycles later with dout=64'h0; occ 1..1 then 0.
//  T2 whitening: skey_in=0 except S[0]=1, S[1]=2, din=0
//     -> dout=64'hFFFFFFFF_FFFFFFFE after 13 cycles.
//  T3 round-trip: skey_in = keyGen constant; 1000 random plaintexts through the encryptor
//     then this block, back-to-back -> dout equals each plaintext in order, 1/cycle.
//  T4 backpressure: stream 20 blocks; do_rdy=0 at cycles 15-19
//     -> di_rdy=0 and do_vld/dout held over 15-19, occ=13; no loss or duplication; order kept.
//  T5 reset: assert clr=0 asynchronously with 6 blocks in flight
//     -> do_vld=0, occ=0, dout=0 immediately; after release, next block decrypts correctly in 13 cycles.
//  T6 rotation edges: reference-model compare on vectors with A[4:0]/B'[4:0] = 0 and 31 at every stage
//     -> bit-exact match.

Source files
------------

// File: rtl/rc5_decrypt_pipe.sv
// RC5-32/12/16 decryptor, one round per registered stage plus an
// output whitening stage; a single advance enable stalls the whole pipe.
module rc5_decrypt_pipe #(
    parameter int ROUNDS = 12,
    parameter int W      = 32
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [2*W*(ROUNDS+1)-1:0]     skey_in,
    input  logic [2*W-1:0]                din,
    input  logic                          di_vld,
    output logic                          di_rdy,
    output logic [2*W-1:0]                dout,
    output logic                          do_vld,
    input  logic                          do_rdy,
    output logic [$clog2(ROUNDS+2)-1:0]   occ,
    output logic                          busy
);

    logic [W-1:0]    a_q  [1:ROUNDS];
    logic [W-1:0]    b_q  [1:ROUNDS];
    logic [W-1:0]    a_nx [1:ROUNDS];
    logic [W-1:0]    b_nx [1:ROUNDS];
    logic [ROUNDS:1] v_q;
    logic            en;
    logic            in_xfer;
    logic            out_xfer;

    assign en       = do_rdy | ~do_vld;
    assign di_rdy   = en;
    assign in_xfer  = di_vld & en;
    assign out_xfer = do_vld & do_rdy;
    assign busy     = (occ != '0);

    // Rotating a doubled word keeps ROTR by 0 an exact identity.
    function automatic logic [W-1:0] rotr(input logic [W-1:0] x,
                                          input logic [4:0]   r);
        logic [2*W-1:0] d;
        d = {x, x} >> r;
        return d[W-1:0];
    endfunction

    always_comb begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] an;
        logic [W-1:0] bn;
        a  = din[2*W-1:W];
        b  = din[W-1:0];
        an = '0;
        bn = '0;
        for (int k = 1; k <= ROUNDS; k++) begin
            bn = rotr(b - skey_in[W*(2*(ROUNDS+1-k)+1) +: W], a[4:0]) ^ a;
            an = rotr(a - skey_in[W*(2*(ROUNDS+1-k)) +: W], bn[4:0]) ^ bn;
            a_nx[k] = an;
            b_nx[k] = bn;
            a = a_q[k];
            b = b_q[k];
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            v_q    <= '0;
            dout   <= '0;
            do_vld <= 1'b0;
            occ    <= '0;
            for (int k = 1; k <= ROUNDS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            if (en) begin
                v_q <= {v_q[ROUNDS-1:1], di_vld};
                // Data only moves with a valid token so idle din never lands in a stage.
                if (di_vld) begin
                    a_q[1] <= a_nx[1];
                    b_q[1] <= b_nx[1];
                end
                for (int k = 2; k <= ROUNDS; k++) begin
                    if (v_q[k-1]) begin
                        a_q[k] <= a_nx[k];
                        b_q[k] <= b_nx[k];
                    end
                end
                do_vld <= v_q[ROUNDS];
                if (v_q[ROUNDS]) begin
                    dout <= {a_q[ROUNDS] - skey_in[W-1:0],
                             b_q[ROUNDS] - skey_in[2*W-1:W]};
                end
            end
            if (in_xfer && !out_xfer) begin
                occ <= occ + 1'b1;
            end else if (out_xfer && !in_xfer) begin
                occ <= occ - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rc5_decrypt_pipe.sv
// Bench for rc5_decrypt_pipe: RC5 encrypt/decrypt/keygen reference model,
// queue scoreboard, randomized traffic and backpressure.
module tb_rc5_decrypt_pipe;

    logic         clk;
    logic         clr;
    logic [831:0] skey_in;
    logic [63:0]  din;
    logic         di_vld;
    logic         di_rdy;
    logic [63:0]  dout;
    logic         do_vld;
    logic         do_rdy;
    logic [3:0]   occ;
    logic         busy;

    rc5_decrypt_pipe #(.ROUNDS(12), .W(32)) dut (
        .clk(clk), .clr(clr), .skey_in(skey_in),
        .din(din), .di_vld(di_vld), .di_rdy(di_rdy),
        .dout(dout), .do_vld(do_vld), .do_rdy(do_rdy),
        .occ(occ), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ct;
        logic [63:0] pt;
    } blk_t;

    blk_t        tx_q[$];
    logic [63:0] exp_q[$];
    int          in_cyc_q[$];
    logic [31:0] S [26];
    int          cyc;
    bit          lat_en;
    int          nerr;
    int          nchk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl_m(input logic [31:0] x, input int r);
        int n;
        n = r & 31;
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] rotr_m(input logic [31:0] x, input int r);
        int n;
        n = r & 31;
        if (n == 0) return x;
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] enc_m(input logic [63:0] pt);
        logic [31:0] a, b;
        a = pt[63:32] + S[0];
        b = pt[31:0] + S[1];
        for (int i = 1; i <= 12; i++) begin
            a = rotl_m(a ^ b, int'(b[4:0])) + S[2*i];
            b = rotl_m(b ^ a, int'(a[4:0])) + S[2*i+1];
        end
        return {a, b};
    endfunction

    function automatic logic [63:0] dec_m(input logic [63:0] ct);
        logic [31:0] a, b;
        a = ct[63:32];
        b = ct[31:0];
        for (int i = 12; i >= 1; i--) begin
            b = rotr_m(b - S[2*i+1], int'(a[4:0])) ^ a;
            a = rotr_m(a - S[2*i], int'(b[4:0])) ^ b;
        end
        return {a - S[0], b - S[1]};
    endfunction

    task automatic keygen();
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        for (int k = 0; k < 4; k++) l[k] = $urandom;
        S[0] = 32'hB7E1_5163;
        for (int k = 1; k < 26; k++) S[k] = S[k-1] + 32'h9E37_79B9;
        a = 0; b = 0; i = 0; j = 0;
        repeat (78) begin
            S[i] = rotl_m(S[i] + a + b, 3);
            a = S[i];
            l[j] = rotl_m(l[j] + a + b, int'(a + b));
            b = l[j];
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    function automatic logic [31:0] tgt(input bit hi);
        return ($urandom & 32'hFFFF_FFE0) | (hi ? 32'd31 : 32'd0);
    endfunction

    // Key chosen so every rotation amount during decryption is 0 or 31.
    task automatic edge_key(input logic [63:0] pt, input logic [25:0] pat,
                            output logic [63:0] ct);
        logic [31:0] a, b, x, t;
        a = pt[63:32];
        b = pt[31:0];
        t = tgt(pat[0]); S[0] = t - a; a = t;
        t = tgt(pat[1]); S[1] = t - b; b = t;
        for (int i = 1; i <= 12; i++) begin
            x = rotl_m(a ^ b, int'(b[4:0]));
            t = tgt(pat[2*i]); S[2*i] = t - x; a = t;
            x = rotl_m(b ^ a, int'(a[4:0]));
            t = tgt(pat[2*i+1]); S[2*i+1] = t - x; b = t;
        end
        ct = {a, b};
    endtask

    task automatic set_key();
        for (int k = 0; k < 26; k++) skey_in[32*k +: 32] = S[k];
    endtask

    task automatic push(input logic [63:0] ct, input logic [63:0] pt);
        blk_t b;
        b.ct = ct;
        b.pt = pt;
        tx_q.push_back(b);
    endtask

    task automatic cycle(input bit offer, input bit rdy);
        int ic;
        @(negedge clk);
        cyc++;
        chk("occ", 64'(occ), 64'(exp_q.size()));
        chk("busy", 64'(busy), 64'(exp_q.size() != 0));
        do_rdy = rdy;
        if (offer && tx_q.size() > 0) begin
            di_vld = 1'b1;
            din    = tx_q[0].ct;
        end else begin
            di_vld = 1'b0;
            din    = {$urandom, $urandom};
        end
        #1;
        chk("di_rdy", 64'(di_rdy), 64'(do_rdy || !do_vld));
        if (do_vld && do_rdy) begin
            chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                chk("dout", dout, exp_q.pop_front());
                ic = in_cyc_q.pop_front();
                if (lat_en) chk("latency", 64'(cyc - ic), 64'd13);
            end
        end
        if (di_vld && di_rdy) begin
            exp_q.push_back(tx_q[0].pt);
            in_cyc_q.push_back(cyc);
            void'(tx_q.pop_front());
        end
    endtask

    task automatic drain(input bit rnd);
        int n;
        bit o, r;
        n = 0;
        while ((tx_q.size() + exp_q.size()) != 0 && n < 3000) begin
            o = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle(o, r);
            n++;
        end
        chk("drain", 64'(tx_q.size() + exp_q.size()), 64'd0);
        repeat (2) cycle(1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pt;
        logic [63:0] ct;
        logic [63:0] held;
        logic [25:0] pats [4];
        nerr = 0; nchk = 0; cyc = 0; lat_en = 1'b1;
        clr = 1'b0; di_vld = 1'b0; do_rdy = 1'b0;
        din = '0; skey_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 64'h0);
        chk("rst_do_vld", 64'(do_vld), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_di_rdy", 64'(di_rdy), 64'd1);
        clr = 1'b1;

        for (int k = 0; k < 26; k++) S[k] = '0;
        set_key();
        push(64'h0, 64'h0);
        drain(1'b0);

        S[0] = 32'd1; S[1] = 32'd2;
        set_key();
        push(64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
        drain(1'b0);

        keygen();
        set_key();
        repeat (1000) begin
            pt = {$urandom, $urandom};
            push(enc_m(pt), pt);
        end
        drain(1'b0);

        lat_en = 1'b0;
        repeat (150) begin
            ct = {$urandom, $urandom};
            push(ct, dec_m(ct));
        end
        drain(1'b1);

        repeat (20) begin
            pt = {$urandom, $urandom};
            push(enc_m(pt), pt);
        end
        held = '0;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b1, !(c >= 15 && c <= 19));
            if (c >= 15 && c <= 19) begin
                chk("bp_di_rdy", 64'(di_rdy), 64'd0);
                chk("bp_do_vld", 64'(do_vld), 64'd1);
                chk("bp_occ", 64'(occ), 64'd13);
                if (c == 15) held = dout;
                else chk("bp_hold", dout, held);
            end
        end
        drain(1'b0);
        lat_en = 1'b1;

        repeat (6) begin
            pt = {$urandom, $urandom};
            push(enc_m(pt), pt);
        end
        repeat (6) cycle(1'b1, 1'b1);
        @(posedge clk);
        #2;
        di_vld = 1'b0;
        chk("rst_mid_occ_pre", 64'(occ), 64'd6);
        clr = 1'b0;
        #1;
        chk("rst_mid_do_vld", 64'(do_vld), 64'd0);
        chk("rst_mid_occ", 64'(occ), 64'd0);
        chk("rst_mid_dout", dout, 64'h0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        exp_q.delete();
        in_cyc_q.delete();
        tx_q.delete();
        @(negedge clk);
        clr = 1'b1;
        pt = {$urandom, $urandom};
        push(enc_m(pt), pt);
        drain(1'b0);

        pats[0] = 26'h0000000;
        pats[1] = 26'h3FFFFFF;
        pats[2] = 26'h2AAAAAA;
        pats[3] = 26'h1555555;
        for (int v = 0; v < 8; v++) begin
            pt = {$urandom, $urandom};
            edge_key(pt, (v < 4) ? pats[v] : 26'($urandom), ct);
            set_key();
            push(ct, pt);
            drain(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
